// File: rtl/pipereg_wb_multi.sv
// Multi-channel writeback pipeline register: one small FIFO per channel with
// age-based flush truncation and a registered single-cycle redirect pulse.
module pipereg_wb_multi #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PREG_W = 6,
  parameter int unsigned ID_W   = 6
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CH-1:0]                     in_valid,
  output logic [NUM_CH-1:0]                     in_ready,
  input  logic [NUM_CH-1:0]                     in_need_wb,
  input  logic [NUM_CH*PREG_W-1:0]              in_prd,
  input  logic [NUM_CH*DATA_W-1:0]              in_result,
  input  logic [NUM_CH-1:0]                     in_redirect_valid,
  input  logic [NUM_CH*DATA_W-1:0]              in_redirect_target,
  input  logic [NUM_CH*(ID_W+1)-1:0]            in_id,
  output logic [NUM_CH-1:0]                     out_valid,
  input  logic [NUM_CH-1:0]                     out_ready,
  output logic [NUM_CH-1:0]                     out_need_wb,
  output logic [NUM_CH*PREG_W-1:0]              out_prd,
  output logic [NUM_CH*DATA_W-1:0]              out_result,
  output logic [NUM_CH*(ID_W+1)-1:0]            out_id,
  input  logic                                  flush_valid,
  input  logic [ID_W:0]                         flush_id,
  output logic                                  redirect_valid,
  output logic [DATA_W-1:0]                     redirect_target,
  output logic [ID_W:0]                         redirect_id,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = ID_W + 1;

  // True when a is strictly older than b; the MSB is the wrap bit.
  function automatic logic is_older(input logic [IW-1:0] a, input logic [IW-1:0] b);
    if (a[ID_W] == b[ID_W]) return a[ID_W-1:0] < b[ID_W-1:0];
    else                    return a[ID_W-1:0] > b[ID_W-1:0];
  endfunction

  logic [NUM_CH-1:0] push_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_pop, wr_base;
    logic [CW-1:0]     count, count_pop, keep, count_trunc;
    logic              stop, pop, push;
    logic [IW-1:0]     cur_id;
    logic              mem_need [DEPTH];
    logic [PREG_W-1:0] mem_prd  [DEPTH];
    logic [DATA_W-1:0] mem_res  [DEPTH];
    logic [IW-1:0]     mem_id   [DEPTH];

    assign cur_id       = in_id[c*IW +: IW];
    assign in_ready[c]  = (count != CW'(DEPTH));
    assign out_valid[c] = (count != '0);
    assign pop          = out_valid[c] & out_ready[c];
    assign push         = in_valid[c] & in_ready[c] & ~(flush_valid & is_older(flush_id, cur_id));
    assign push_ok[c]   = push;

    assign out_need_wb[c]               = mem_need[rd_ptr];
    assign out_prd[c*PREG_W +: PREG_W]  = mem_prd[rd_ptr];
    assign out_result[c*DATA_W +: DATA_W] = mem_res[rd_ptr];
    assign out_id[c*IW +: IW]           = mem_id[rd_ptr];
    assign occupancy[c*CW +: CW]        = count;

    // Pop first, then keep the run of entries from the head that are not younger
    // than flush_id; entries are age ordered so the first younger one ends the run.
    always_comb begin
      rd_pop    = pop ? rd_ptr + PW'(1) : rd_ptr;
      count_pop = count - CW'(pop);
      keep      = '0;
      stop      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < count_pop && !stop) begin
          if (is_older(flush_id, mem_id[rd_pop + PW'(i)])) stop = 1'b1;
          else keep = keep + CW'(1);
        end
      end
      if (flush_valid) begin
        count_trunc = keep;
        wr_base     = rd_pop + PW'(keep);
      end else begin
        count_trunc = count_pop;
        wr_base     = wr_ptr;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_need[i] <= 1'b0;
          mem_prd[i]  <= '0;
          mem_res[i]  <= '0;
          mem_id[i]   <= '0;
        end
      end else begin
        rd_ptr <= rd_pop;
        wr_ptr <= wr_base + PW'(push);
        count  <= count_trunc + CW'(push);
        if (push) begin
          mem_need[wr_base] <= in_need_wb[c];
          mem_prd[wr_base]  <= in_prd[c*PREG_W +: PREG_W];
          mem_res[wr_base]  <= in_result[c*DATA_W +: DATA_W];
          mem_id[wr_base]   <= cur_id;
        end
      end
    end
  end

  logic              cand_v, capture;
  logic [IW-1:0]     cand_id;
  logic [DATA_W-1:0] cand_tgt;

  // Oldest pushed redirect wins; strict comparison keeps the lowest channel on a tie.
  always_comb begin
    cand_v   = 1'b0;
    cand_id  = '0;
    cand_tgt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok[c] && in_redirect_valid[c] &&
          (!cand_v || is_older(in_id[c*IW +: IW], cand_id))) begin
        cand_v   = 1'b1;
        cand_id  = in_id[c*IW +: IW];
        cand_tgt = in_redirect_target[c*DATA_W +: DATA_W];
      end
    end
    capture = cand_v & ~(redirect_valid & is_older(redirect_id, cand_id));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
      redirect_id     <= '0;
    end else begin
      redirect_valid <= capture;
      if (capture) begin
        redirect_target <= cand_tgt;
        redirect_id     <= cand_id;
      end
    end
  end

endmodule

// File: tb/tb_pipereg_wb_multi.sv
// Scoreboard bench for pipereg_wb_multi: stimulus updates queue-based model,
// a negedge monitor compares the DUT head/status/redirect against it.
module tb_pipereg_wb_multi;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 64;
  localparam int PREG_W = 6;
  localparam int ID_W   = 6;
  localparam int IW     = ID_W + 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic                         clock, reset;
  logic [NUM_CH-1:0]            in_valid, in_ready, in_need_wb, in_redirect_valid;
  logic [NUM_CH*PREG_W-1:0]     in_prd;
  logic [NUM_CH*DATA_W-1:0]     in_result, in_redirect_target;
  logic [NUM_CH*IW-1:0]         in_id;
  logic [NUM_CH-1:0]            out_valid, out_ready, out_need_wb;
  logic [NUM_CH*PREG_W-1:0]     out_prd;
  logic [NUM_CH*DATA_W-1:0]     out_result;
  logic [NUM_CH*IW-1:0]         out_id;
  logic                         flush_valid;
  logic [IW-1:0]                flush_id;
  logic                         redirect_valid;
  logic [DATA_W-1:0]            redirect_target;
  logic [IW-1:0]                redirect_id;
  logic [NUM_CH*CW-1:0]         occupancy;

  pipereg_wb_multi #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W), .ID_W(ID_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_need_wb(in_need_wb), .in_prd(in_prd),
    .in_result(in_result), .in_redirect_valid(in_redirect_valid),
    .in_redirect_target(in_redirect_target), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_need_wb(out_need_wb),
    .out_prd(out_prd), .out_result(out_result), .out_id(out_id),
    .flush_valid(flush_valid), .flush_id(flush_id),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .redirect_id(redirect_id), .occupancy(occupancy)
  );

  typedef struct {
    logic              need;
    logic [PREG_W-1:0] prd;
    logic [DATA_W-1:0] res;
    logic [IW-1:0]     id;
  } ent_t;

  typedef struct {
    bit                v;
    logic [IW-1:0]     id;
    logic [DATA_W-1:0] tgt;
  } rd_t;

  ent_t       q[NUM_CH][$];
  rd_t        rq[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         mon_en = 0;
  bit         pend_v = 0;
  logic [IW-1:0] pend_id = '0;
  logic [IW-1:0] next_id;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Age by modular distance: a is older when b lies 1..63 steps ahead of a.
  function automatic bit older(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW-1:0] d;
    d = b - a;
    return (d != 0) && (d < 7'd64);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: status and head fields every cycle; pop the model where a pop happens.
  initial begin
    rd_t r;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        for (int c = 0; c < NUM_CH; c++) begin
          check("occupancy", 64'(occupancy[c*CW +: CW]), 64'(q[c].size()));
          check("out_valid", 64'(out_valid[c]), 64'(q[c].size() != 0));
          check("in_ready", 64'(in_ready[c]), 64'(q[c].size() != DEPTH));
          if (q[c].size() != 0) begin
            check("out_id", 64'(out_id[c*IW +: IW]), 64'(q[c][0].id));
            check("out_prd", 64'(out_prd[c*PREG_W +: PREG_W]), 64'(q[c][0].prd));
            check("out_result", out_result[c*DATA_W +: DATA_W], q[c][0].res);
            check("out_need_wb", 64'(out_need_wb[c]), 64'(q[c][0].need));
            if (out_ready[c]) void'(q[c].pop_front());
          end
        end
        if (rq.size() != 0) r = rq.pop_front();
        else begin
          r.v = 1'b0; r.id = '0; r.tgt = '0;
        end
        check("redirect_valid", 64'(redirect_valid), 64'(r.v));
        if (r.v) begin
          check("redirect_id", 64'(redirect_id), 64'(r.id));
          check("redirect_target", redirect_target, r.tgt);
        end
      end
    end
  end

  // One clock of stimulus; after the monitor's pop the model applies flush then push.
  task automatic step(input logic [1:0] v, input logic [1:0] rv, input logic [1:0] ordy,
                      input logic fv, input logic [IW-1:0] fid,
                      input logic [IW-1:0] id0, input logic [IW-1:0] id1);
    logic [IW-1:0]     ids [NUM_CH];
    bit                rdy [NUM_CH];
    ent_t              e;
    ent_t              tmp[$];
    bit                cv;
    logic [IW-1:0]     cid;
    logic [DATA_W-1:0] ctgt;
    rd_t               r;
    ids[0] = id0;
    ids[1] = id1;
    @(posedge clock);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      rdy[c] = q[c].size() < DEPTH;
      in_id[c*IW +: IW]                     = ids[c];
      in_prd[c*PREG_W +: PREG_W]            = PREG_W'($urandom);
      in_result[c*DATA_W +: DATA_W]         = {$urandom, $urandom};
      in_redirect_target[c*DATA_W +: DATA_W] = {$urandom, $urandom};
      in_need_wb[c]                         = 1'($urandom);
    end
    in_valid = v; in_redirect_valid = rv; out_ready = ordy;
    flush_valid = fv; flush_id = fid;
    @(negedge clock);
    #1;
    cv = 0; cid = '0; ctgt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fv) begin
        tmp.delete();
        for (int i = 0; i < q[c].size(); i++)
          if (!older(fid, q[c][i].id)) tmp.push_back(q[c][i]);
        q[c] = tmp;
      end
      if (v[c] && rdy[c] && !(fv && older(fid, ids[c]))) begin
        e.need = in_need_wb[c];
        e.prd  = in_prd[c*PREG_W +: PREG_W];
        e.res  = in_result[c*DATA_W +: DATA_W];
        e.id   = ids[c];
        q[c].push_back(e);
        if (rv[c] && (!cv || older(ids[c], cid))) begin
          cv = 1; cid = ids[c]; ctgt = in_redirect_target[c*DATA_W +: DATA_W];
        end
      end
    end
    r.v = cv && !(pend_v && older(pend_id, cid));
    r.id = cid;
    r.tgt = ctgt;
    rq.push_back(r);
    pend_v = r.v;
    pend_id = cid;
  endtask

  task automatic drain();
    repeat (3) step(2'b00, 2'b00, 2'b11, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [1:0] v, rv, ordy;
    logic       fv;
    logic [IW-1:0] fid;
    reset = 1'b1;
    in_valid = '0; in_need_wb = '0; in_prd = '0; in_result = '0; in_redirect_valid = '0;
    in_redirect_target = '0; in_id = '0; out_ready = '0; flush_valid = 1'b0; flush_id = '0;
    repeat (2) @(posedge clock);
    #2;
    check("rst occupancy", 64'(occupancy), 64'(0));
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(2'b11));
    check("rst redirect_valid", 64'(redirect_valid), 64'(0));
    check("rst redirect_id", 64'(redirect_id), 64'(0));
    check("rst redirect_target", redirect_target, 64'(0));
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1;

    // Fill and stall on channel 0, then release.
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, 7'd3, '0);
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, 7'd4, '0);
    step(2'b00, 2'b00, 2'b00, 1'b0, '0, '0, '0);
    drain();
    // Push and pop together at occupancy 1, wrapping the pointers.
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, 7'd10, '0);
    for (int i = 0; i < 10; i++) step(2'b01, 2'b00, 2'b01, 1'b0, '0, 7'(11 + i), '0);
    drain();
    // Flush keeps 5, drops 7, refuses 9.
    step(2'b10, 2'b00, 2'b00, 1'b0, '0, '0, 7'd5);
    step(2'b10, 2'b00, 2'b00, 1'b0, '0, '0, 7'd7);
    step(2'b10, 2'b00, 2'b00, 1'b1, 7'd5, '0, 7'd9);
    step(2'b00, 2'b00, 2'b00, 1'b0, '0, '0, '0);
    drain();
    // Wrap-bit ages.
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, {1'b1, 6'd61}, '0);
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, {1'b1, 6'd63}, '0);
    step(2'b00, 2'b00, 2'b00, 1'b1, {1'b1, 6'd62}, '0, '0);
    drain();
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, {1'b1, 6'd62}, '0);
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, {1'b0, 6'd3}, '0);
    step(2'b00, 2'b00, 2'b00, 1'b1, {1'b0, 6'd1}, '0, '0);
    drain();
    // Redirect arbitration, flush kill, and suppression by an older pending redirect.
    step(2'b11, 2'b11, 2'b11, 1'b0, '0, 7'd10, 7'd8);
    drain();
    step(2'b11, 2'b11, 2'b11, 1'b1, 7'd6, 7'd10, 7'd8);
    drain();
    step(2'b01, 2'b01, 2'b11, 1'b0, '0, 7'd40, '0);
    step(2'b10, 2'b10, 2'b11, 1'b0, '0, '0, 7'd41);
    drain();

    next_id = 7'd50;
    for (int n = 0; n < 400; n++) begin
      v    = 2'($urandom);
      rv   = 2'($urandom);
      ordy = {($urandom % 4) != 0, ($urandom % 4) != 0};
      fv   = ($urandom % 10) == 0;
      fid  = next_id - 7'($urandom_range(1, 4));
      step(v, rv, ordy, fv, fid, next_id, next_id + 7'd1);
      next_id = fv ? fid + 7'd1 : next_id + 7'd2;
    end
    drain();

    // Asynchronous reset with two entries stored and a redirect pending.
    step(2'b01, 2'b00, 2'b00, 1'b0, '0, 7'd20, '0);
    step(2'b01, 2'b01, 2'b00, 1'b0, '0, 7'd21, '0);
    @(posedge clock);
    #2;
    mon_en = 0;
    check("pre-reset occupancy", 64'(occupancy[CW-1:0]), 64'(q[0].size()));
    check("pre-reset redirect_valid", 64'(redirect_valid), 64'(rq[0].v));
    reset = 1'b1;
    #1;
    check("async occupancy", 64'(occupancy), 64'(0));
    check("async out_valid", 64'(out_valid), 64'(0));
    check("async redirect_valid", 64'(redirect_valid), 64'(0));
    for (int c = 0; c < NUM_CH; c++) q[c].delete();
    rq.delete();
    pend_v = 0;
    in_valid = '0; in_redirect_valid = '0; out_ready = '0; flush_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1;
    step(2'b11, 2'b00, 2'b00, 1'b0, '0, 7'd30, 7'd31);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
